// File: rtl/ddr_io_bus.sv
// rtl/ddr_io_bus.sv - DDR pad interface: output serializer with matched tristate, input deserializer with bit-slip pairing
module ddr_io_bus #(
    parameter int WIDTH   = 8,
    parameter int OUT_LAT = 2,
    parameter int IN_LAT  = 2
) (
    input  logic             SCLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic             T,
    output logic [WIDTH-1:0] Q,
    output logic             TQ,
    input  logic [WIDTH-1:0] D,
    input  logic             BSLIP,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic             VALID,
    output logic             SLIP
);

    localparam logic [2:0] FILL_DONE = 3'(IN_LAT + 1);

    // Stage 0 is the sampling flop; the last stage changes OUT_LAT edges after sampling.
    logic [OUT_LAT:0][WIDTH-1:0] d0_pipe;
    logic [OUT_LAT:0][WIDTH-1:0] d1_pipe;
    logic [OUT_LAT:0]            oe_pipe;
    logic [WIDTH-1:0]            d1_fall;

    logic [WIDTH-1:0]            rise_smp;
    logic [WIDTH-1:0]            fall_smp;
    logic [WIDTH-1:0]            fall_prev;
    logic [WIDTH-1:0]            pair0;
    logic [WIDTH-1:0]            pair1;
    logic [IN_LAT-1:0][WIDTH-1:0] q0_pipe;
    logic [IN_LAT-1:0][WIDTH-1:0] q1_pipe;
    logic [2:0]                  fill;

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            d0_pipe <= '0;
            d1_pipe <= '0;
            oe_pipe <= '0;
        end else begin
            d0_pipe[0] <= D0;
            d1_pipe[0] <= D1;
            oe_pipe[0] <= ~T;
            for (int i = 1; i <= OUT_LAT; i++) begin
                d0_pipe[i] <= d0_pipe[i-1];
                d1_pipe[i] <= d1_pipe[i-1];
                oe_pipe[i] <= oe_pipe[i-1];
            end
        end
    end

    // Low-phase data is relaunched from the falling edge so the pad mux only ever
    // switches between two stable registers.
    always_ff @(negedge SCLK or negedge RST) begin
        if (!RST) begin
            d1_fall <= '0;
        end else begin
            d1_fall <= d1_pipe[OUT_LAT];
        end
    end

    assign Q  = SCLK ? d0_pipe[OUT_LAT] : d1_fall;
    // Enable is carried inverted so an all-zero reset state means lanes released.
    assign TQ = ~oe_pipe[OUT_LAT];

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            rise_smp  <= '0;
            fall_prev <= '0;
        end else begin
            rise_smp  <= D;
            fall_prev <= fall_smp;
        end
    end

    always_ff @(negedge SCLK or negedge RST) begin
        if (!RST) begin
            fall_smp <= '0;
        end else begin
            fall_smp <= D;
        end
    end

    // Slipped pairing takes the falling sample that preceded the rising sample.
    always_comb begin
        pair0 = rise_smp;
        pair1 = fall_smp;
        if (SLIP) begin
            pair0 = fall_prev;
            pair1 = rise_smp;
        end
    end

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            q0_pipe <= '0;
            q1_pipe <= '0;
        end else begin
            q0_pipe[0] <= pair0;
            q1_pipe[0] <= pair1;
            for (int i = 1; i < IN_LAT; i++) begin
                q0_pipe[i] <= q0_pipe[i-1];
                q1_pipe[i] <= q1_pipe[i-1];
            end
        end
    end

    assign Q0 = q0_pipe[IN_LAT-1];
    assign Q1 = q1_pipe[IN_LAT-1];

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            SLIP <= 1'b0;
            fill <= '0;
        end else if (BSLIP) begin
            SLIP <= ~SLIP;
            fill <= '0;
        end else if (fill != FILL_DONE) begin
            fill <= fill + 3'd1;
        end
    end

    assign VALID = (fill == FILL_DONE);

endmodule
